// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
//   Round-robin arbiter in front of an 8-way (3-to-8) decoded resource.
//   One requester at a time owns the resource. The grant is held until the
//   owner pulses done or drops its request. Every release is followed by a
//   one-cycle idle bubble, and priority then rotates to the index after the
//   released owner.
//
//   Optional feature: define ARB_TIMEOUT_EN to add a 16-bit hold counter.
//   With it, a grant held for MAX_HOLD cycles is forcibly released and
//   timeout pulses for one cycle. Without it, timeout is constant 0.
//
// Parameters
//   MAX_HOLD      maximum grant length in cycles with ARB_TIMEOUT_EN (2..65535)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[7:0]      level requests, held until served
//   done          owner finished, only looked at while a grant is active
//   grant_valid   a grant is active
//   grant_idx     encoded owner index, 0 when idle
//   grant_onehot  decoded owner, 8'h00 when idle
//   timeout       one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic       grant_valid,
   output logic [2:0] grant_idx,
   output logic [7:0] grant_onehot,
   output logic       timeout
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Catch an out-of-range hold limit at elaboration time.
   if ((MAX_HOLD < 2) || (MAX_HOLD > 65535)) begin : g_bad_max_hold
      $error("rr_decode_arbiter: MAX_HOLD out of range 2..65535");
   end

   // First set request bit, searching ptr, ptr+1, ..., ptr+7 (mod 8).
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = p + 3'(i);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // 3-to-8 decode of the owner index.
   function automatic logic [7:0] dec3to8(input logic [2:0] idx);
      dec3to8 = 8'h01 << idx;
   endfunction

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic       grant_valid_q, grant_valid_d;
   logic [2:0] grant_idx_q, grant_idx_d;
   logic [7:0] grant_onehot_q, grant_onehot_d;
   logic       release_s;
   logic [2:0] pick_s;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   // Release condition and the next candidate owner.
   always_comb begin
      release_s = done | ~req[grant_idx_q];
      pick_s    = rr_pick(req, ptr_q);
   end

   // Next-state and next-output computation.
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      grant_valid_d  = grant_valid_q;
      grant_idx_d    = grant_idx_q;
      grant_onehot_d = grant_onehot_q;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d     = hold_cnt_q;
      timeout_d      = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req != 8'h00) begin
               state_d        = ST_GRANT;
               grant_valid_d  = 1'b1;
               grant_idx_d    = pick_s;
               grant_onehot_d = dec3to8(pick_s);
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d     = 16'h0000;
`endif
            end else begin
               grant_valid_d  = 1'b0;
               grant_idx_d    = 3'd0;
               grant_onehot_d = 8'h00;
            end
         end
         ST_GRANT: begin
            // done and withdrawal together are one release; a normal release
            // also wins over a timeout on the same edge.
            if (release_s) begin
               state_d        = ST_IDLE;
               ptr_d          = grant_idx_q + 3'd1;
               grant_valid_d  = 1'b0;
               grant_idx_d    = 3'd0;
               grant_onehot_d = 8'h00;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d        = ST_IDLE;
               ptr_d          = grant_idx_q + 3'd1;
               grant_valid_d  = 1'b0;
               grant_idx_d    = 3'd0;
               grant_onehot_d = 8'h00;
               timeout_d      = 1'b1;
            end else begin
               hold_cnt_d     = hold_cnt_q + 16'd1;
`else
            end else begin
               state_d        = ST_GRANT;
`endif
            end
         end
         default: begin
            state_d        = ST_IDLE;
            ptr_d          = 3'd0;
            grant_valid_d  = 1'b0;
            grant_idx_d    = 3'd0;
            grant_onehot_d = 8'h00;
         end
      endcase
   end

   // State, rotate pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ptr_q          <= 3'd0;
         grant_valid_q  <= 1'b0;
         grant_idx_q    <= 3'd0;
         grant_onehot_q <= 8'h00;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q     <= 16'h0000;
         timeout_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         grant_valid_q  <= grant_valid_d;
         grant_idx_q    <= grant_idx_d;
         grant_onehot_q <= grant_onehot_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q     <= hold_cnt_d;
         timeout_q      <= timeout_d;
`endif
      end
   end

   assign grant_valid  = grant_valid_q;
   assign grant_idx    = grant_idx_q;
   assign grant_onehot = grant_onehot_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout      = timeout_q;
`else
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decode_arbiter
//   Directed-vector bench for rr_decode_arbiter with hand-computed
//   expectations. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at that same point, away from the active edge.
//   Builds with or without ARB_TIMEOUT_EN; the DUT uses MAX_HOLD=4.
// ---------------------------------------------------------------------------
module tb_rr_decode_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] grant_onehot;
   logic       timeout;

   int n_chk;
   int n_bad;

   rr_decode_arbiter #(.MAX_HOLD(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .done         (done),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot),
      .timeout      (timeout)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare all four outputs against an expected grant state.
   task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                             input logic to);
      logic [7:0] oh;
      oh = v ? (8'h01 << idx) : 8'h00;
      check({tag, "_valid"},   32'(grant_valid),  32'(v));
      check({tag, "_idx"},     32'(grant_idx),    v ? 32'(idx) : 32'd0);
      check({tag, "_onehot"},  32'(grant_onehot), 32'(oh));
      check({tag, "_timeout"}, 32'(timeout),      32'(to));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      #1;
      expect_out("rst", 1'b0, 3'd0, 1'b0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      #12;
      expect_out("por", 1'b0, 3'd0, 1'b0);
      step();
      rst_n = 1'b1;

      // Idle with no requests; done while idle must be ignored.
      for (int i = 0; i < 5; i++) begin
         done = (i == 2);
         step();
         expect_out("idle", 1'b0, 3'd0, 1'b0);
      end
      done = 1'b0;

      // Single requester 0: grant, hold, done, bubble, re-grant.
      req = 8'h01;
      step();
      expect_out("r0_grant", 1'b1, 3'd0, 1'b0);
      step();
      expect_out("r0_hold1", 1'b1, 3'd0, 1'b0);
      step();
      expect_out("r0_hold2", 1'b1, 3'd0, 1'b0);
      done = 1'b1;
      step();
      expect_out("r0_rel", 1'b0, 3'd0, 1'b0);
      done = 1'b0;
      step();
      expect_out("r0_regrant", 1'b1, 3'd0, 1'b0);
      done = 1'b1;
      req  = 8'h00;
      step();
      expect_out("r0_rel2", 1'b0, 3'd0, 1'b0);
      done = 1'b0;

      // All requesting: rotation 0..7,0 with a bubble between grants.
      do_reset();
      req = 8'hFF;
      for (int n = 0; n < 9; n++) begin
         step();
         expect_out("rot_grant", 1'b1, 3'(n % 8), 1'b0);
         done = 1'b1;
         step();
         expect_out("rot_bubble", 1'b0, 3'd0, 1'b0);
         done = 1'b0;
      end

      // Continue to 6, then only requesters 0 and 6 remain: 0 wins, then 6.
      for (int n = 1; n < 7; n++) begin
         step();
         expect_out("pre_wrap", 1'b1, 3'(n), 1'b0);
         done = 1'b1;
         if (n == 6) req = 8'h41;
         step();
         expect_out("pre_wrap_rel", 1'b0, 3'd0, 1'b0);
         done = 1'b0;
      end
      step();
      expect_out("wrap_0", 1'b1, 3'd0, 1'b0);
      done = 1'b1;
      step();
      expect_out("wrap_0_rel", 1'b0, 3'd0, 1'b0);
      done = 1'b0;
      step();
      expect_out("wrap_6", 1'b1, 3'd6, 1'b0);
      done = 1'b1;
      req  = 8'h00;
      step();
      expect_out("wrap_6_rel", 1'b0, 3'd0, 1'b0);
      done = 1'b0;

      // Withdrawal: grant to 3, other bits change without effect, then drop.
      do_reset();
      req = 8'h08;
      step();
      expect_out("wd_grant3", 1'b1, 3'd3, 1'b0);
      req = 8'h0C;
      step();
      expect_out("wd_other_bits", 1'b1, 3'd3, 1'b0);
      req = 8'h21;
      step();
      expect_out("wd_release", 1'b0, 3'd0, 1'b0);
      step();
      // ptr=4 means search 4,5,... so 5 beats 0.
      expect_out("wd_ptr4", 1'b1, 3'd5, 1'b0);

      // Asynchronous reset mid-grant clears outputs before the next edge.
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 1'b0, 3'd0, 1'b0);
      step();
      rst_n = 1'b1;
      req   = 8'h00;

      // Hold behaviour with requests 0 and 2 and no done.
      do_reset();
      req = 8'h05;
      step();
      expect_out("to_grant0", 1'b1, 3'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("to_hold", 1'b1, 3'd0, 1'b0);
      end
      step();
      expect_out("to_forced", 1'b0, 3'd0, 1'b1);
      step();
      expect_out("to_next2", 1'b1, 3'd2, 1'b0);
`else
      for (int i = 0; i < 10; i++) begin
         step();
         expect_out("nto_hold", 1'b1, 3'd0, 1'b0);
      end
`endif
      req = 8'h00;
      step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
